led_shifter: RTL and testbench

LED_SHIFTER -- requirements
Module: led_shifter

---
 rtl/lamp_pkg.sv | 17 +
 rtl/led_shifter_if.sv | 14 +
 rtl/led_shifter_sclk_gen.sv | 38 +++
 rtl/led_shifter.sv | 149 ++++++++++++++
 tb/tb_led_shifter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lamp_pkg.sv
// Constants shared by the LED lamp framebuffer and the serial frame shifter,
// plus the shifter's state encoding.
package lamp_pkg;

  localparam int c_ch_per_board   = 32;
  localparam int c_bpc_default    = 12;
  localparam int c_time_w_default = 10;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SHIFT,
    LATCH,
    HOLD
  } shift_state_t;

endpackage

// File: rtl/led_shifter_if.sv
// Framebuffer read port: the shifter drives the address, and the framebuffer
// returns the word one clock later.
interface led_shifter_if #(
  parameter int c_addr_w = 10,
  parameter int c_bpc    = lamp_pkg::c_bpc_default
);

  logic [c_addr_w-1:0] raddr;
  logic [c_bpc-1:0]    rdata;

  modport master (output raddr, input rdata);
  modport slave  (input raddr, output rdata);

endinterface

// File: rtl/led_shifter_sclk_gen.sv
// Half-period timer for the serial clock. It emits a rise strobe at the end of
// each low half and a fall strobe at the end of each high half.
module sclk_gen #(
  parameter int c_clkdiv = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic en,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int c_cnt_w = (c_clkdiv > 1) ? $clog2(c_clkdiv) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_clkdiv - 1);

  logic [c_cnt_w-1:0] cnt;
  logic               high;
  logic               half_end;

  assign half_end  = en && (cnt == c_last);
  assign rise_tick = half_end && !high;
  assign fall_tick = half_end && high;

  // Dropping enable parks the timer at the start of a low half, so every
  // enabled stretch begins with a full low phase.
  always_ff @(posedge i_clk) begin
    if (i_rst || !en) begin
      cnt  <= '0;
      high <= 1'b0;
    end else if (cnt == c_last) begin
      cnt  <= '0;
      high <= ~high;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_shifter.sv
// Streams one framebuffer frame MSB-first into the LED driver chain, then
// latches it and holds it for a programmable number of sclk periods.
module led_shifter
  import lamp_pkg::*;
#(
  parameter int c_ledboards = 30,
  parameter int c_bpc       = c_bpc_default,
  parameter int c_channels  = c_ledboards * c_ch_per_board,
  parameter int c_addr_w    = $clog2(c_channels),
  parameter int c_time_w    = c_time_w_default,
  parameter int c_clkdiv    = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  led_shifter_if.master       fb,
  input  logic [c_time_w-1:0] i_time,
  output logic                o_sclk,
  output logic                o_sdata,
  output logic                o_lat,
  output logic                o_busy,
  output logic                o_done
);

  localparam int c_bit_w = (c_bpc > 1) ? $clog2(c_bpc) : 1;
  localparam logic [c_bit_w-1:0]  c_last_bit  = c_bit_w'(c_bpc - 1);
  localparam logic [c_addr_w-1:0] c_last_word = c_addr_w'(c_channels - 1);

  shift_state_t        state, state_next;
  logic [c_bpc-1:0]    shreg;
  logic [c_bit_w-1:0]  bit_cnt;
  logic [c_addr_w-1:0] word_cnt, raddr, raddr_adv;
  logic [c_time_w-1:0] hold_cnt;
  logic                fetch_wait, sclk_en, rise_tick, fall_tick;
  logic                start_fetch, load_word, shift_bit, enter_latch, finish;

  assign sclk_en = state inside {SHIFT, LATCH, HOLD};

  sclk_gen #(.c_clkdiv(c_clkdiv)) u_sclk_gen (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .en        (sclk_en),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  // The prefetch address runs one word ahead and sticks at the last word.
  assign raddr_adv = (raddr < c_last_word) ? raddr + 1'b1 : raddr;
  assign fb.raddr  = raddr;
  assign o_sdata   = (state == SHIFT) && shreg[c_bpc-1];
  assign o_busy    = (state != IDLE);

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    start_fetch = 1'b0;
    load_word   = 1'b0;
    shift_bit   = 1'b0;
    enter_latch = 1'b0;
    finish      = 1'b0;
    case (state)
      IDLE: if (i_start) begin
        state_next  = FETCH;
        start_fetch = 1'b1;
      end
      FETCH: if (fetch_wait) begin
        state_next = SHIFT;
        load_word  = 1'b1;
      end
      SHIFT: if (fall_tick) begin
        if (bit_cnt != c_last_bit) begin
          shift_bit = 1'b1;
        end else if (word_cnt != c_last_word) begin
          load_word = 1'b1;
        end else begin
          state_next  = LATCH;
          enter_latch = 1'b1;
        end
      end
      LATCH: if (fall_tick) begin
        if (hold_cnt == '0) begin
          state_next = IDLE;
          finish     = 1'b1;
        end else begin
          state_next = HOLD;
        end
      end
      HOLD: if (fall_tick && hold_cnt == c_time_w'(1)) begin
        state_next = IDLE;
        finish     = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Word loads and bit shifts happen only on fall strobes, while sclk is low.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      raddr      <= '0;
      hold_cnt   <= '0;
      fetch_wait <= 1'b0;
      o_sclk     <= 1'b0;
      o_lat      <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_done <= finish;
      if (start_fetch) begin
        raddr      <= '0;
        fetch_wait <= 1'b0;
      end
      if (state == FETCH) fetch_wait <= 1'b1;
      if (load_word) begin
        shreg    <= fb.rdata;
        bit_cnt  <= '0;
        word_cnt <= (state == FETCH) ? '0 : word_cnt + 1'b1;
        raddr    <= raddr_adv;
      end else if (shift_bit) begin
        shreg   <= {shreg[c_bpc-2:0], 1'b0};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (state == SHIFT && rise_tick) o_sclk <= 1'b1;
      else if (fall_tick)              o_sclk <= 1'b0;
      if (enter_latch) begin
        o_lat    <= 1'b1;
        hold_cnt <= i_time;
      end else if (state == LATCH && fall_tick) begin
        o_lat <= 1'b0;
      end else if (state == HOLD && fall_tick) begin
        hold_cnt <= hold_cnt - 1'b1;
      end
      if (finish) begin
        raddr      <= '0;
        word_cnt   <= '0;
        bit_cnt    <= '0;
        hold_cnt   <= '0;
        shreg      <= '0;
        fetch_wait <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_led_shifter.sv
// Bench for led_shifter: one single-board instance at clkdiv=1 and one at
// clkdiv=2, each fed by a behavioural framebuffer and compared to a bitstream model.
module tb_led_shifter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b1, start_a = 1'b0;
  logic [9:0] time_a = '0;
  logic       sclk_a, sdata_a, lat_a, busy_a, done_a;
  logic       rst_b = 1'b1, start_b = 1'b0;
  logic [9:0] time_b = '0;
  logic       sclk_b, sdata_b, lat_b, busy_b, done_b;

  led_shifter_if #(.c_addr_w(5), .c_bpc(12)) fb_a ();
  led_shifter_if #(.c_addr_w(5), .c_bpc(12)) fb_b ();

  led_shifter #(.c_ledboards(1), .c_clkdiv(1)) dut_a (
    .i_clk(clk), .i_rst(rst_a), .i_start(start_a), .fb(fb_a), .i_time(time_a),
    .o_sclk(sclk_a), .o_sdata(sdata_a), .o_lat(lat_a), .o_busy(busy_a), .o_done(done_a)
  );

  led_shifter #(.c_ledboards(1), .c_clkdiv(2)) dut_b (
    .i_clk(clk), .i_rst(rst_b), .i_start(start_b), .fb(fb_b), .i_time(time_b),
    .o_sclk(sclk_b), .o_sdata(sdata_b), .o_lat(lat_b), .o_busy(busy_b), .o_done(done_b)
  );

  logic [11:0] mem_a [32];
  logic [11:0] mem_b [32];

  always @(posedge clk) begin
    fb_a.rdata <= mem_a[fb_a.raddr];
    fb_b.rdata <= mem_b[fb_b.raddr];
  end

  int checks = 0, failures = 0;
  bit bits_a[$], bits_b[$], exp_a[$];

  int sample_idx = 0;
  logic prev_sclk_a = 0, prev_sdata_a = 0, prev_lat_a = 0;
  logic [4:0] prev_raddr_a = '0, prev_raddr_b = '0;
  int lat_rise_idx_a = 0, lat_fall_idx_a = 0, lat_width_a = 0, lat_pulses_a = 0;
  int done_count_a = 0, done_idx_a = 0, sdata_viol_a = 0, raddr_viol_a = 0;
  logic prev_sclk_b = 0, prev_sdata_b = 0;
  int last_rise_b = -1, high_run_b = 0, period_viol_b = 0;
  int done_count_b = 0, sdata_viol_b = 0, raddr_viol_b = 0;

  // Observes both instances on the falling edge, away from the active edge.
  always @(negedge clk) begin
    sample_idx++;
    if (sclk_a && !prev_sclk_a) bits_a.push_back(sdata_a);
    if (sclk_a && prev_sclk_a && sdata_a !== prev_sdata_a) sdata_viol_a++;
    if (busy_a && fb_a.raddr < prev_raddr_a) raddr_viol_a++;
    if (lat_a && !prev_lat_a) lat_rise_idx_a = sample_idx;
    if (!lat_a && prev_lat_a) begin
      lat_fall_idx_a = sample_idx;
      lat_width_a = sample_idx - lat_rise_idx_a;
      lat_pulses_a++;
    end
    if (done_a) begin
      done_count_a++;
      done_idx_a = sample_idx;
    end
    if (sclk_b && !prev_sclk_b) begin
      bits_b.push_back(sdata_b);
      if (last_rise_b >= 0 && sample_idx - last_rise_b != 4) period_viol_b++;
      last_rise_b = sample_idx;
    end
    if (sclk_b) high_run_b++;
    else begin
      if (prev_sclk_b && high_run_b != 2) period_viol_b++;
      high_run_b = 0;
    end
    if (sclk_b && prev_sclk_b && sdata_b !== prev_sdata_b) sdata_viol_b++;
    if (busy_b && fb_b.raddr < prev_raddr_b) raddr_viol_b++;
    if (done_b) done_count_b++;
    prev_sclk_a = sclk_a; prev_sdata_a = sdata_a; prev_lat_a = lat_a;
    prev_raddr_a = fb_a.raddr;
    prev_sclk_b = sclk_b; prev_sdata_b = sdata_b; prev_raddr_b = fb_b.raddr;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Expected serial stream: words in address order, each MSB first.
  task automatic build_exp_a(input int copies);
    exp_a.delete();
    for (int c = 0; c < copies; c++)
      for (int w = 0; w < 32; w++)
        for (int b = 11; b >= 0; b--) exp_a.push_back(mem_a[w][b]);
  endtask

  function automatic int stream_mismatch_a();
    int m;
    m = (bits_a.size() > exp_a.size()) ? bits_a.size() - exp_a.size()
                                       : exp_a.size() - bits_a.size();
    for (int i = 0; i < bits_a.size() && i < exp_a.size(); i++)
      if (bits_a[i] !== exp_a[i]) m++;
    return m;
  endfunction

  task automatic wait_done_a(input string tag, input int target);
    int n = 0;
    while (done_count_a < target && n < 4000) begin tick(); n++; end
    checks++;
    if (done_count_a < target) begin
      failures++;
      $display("[TB] FAIL %s_timeout: done pulses=%0d required=%0d", tag, done_count_a, target);
    end
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (3) tick();
    checks++;
    if ({sclk_a, sdata_a, lat_a, busy_a, done_a} !== 5'b0) begin
      failures++;
      $display("[TB] FAIL reset_outputs_a: got=%b required=00000", {sclk_a, sdata_a, lat_a, busy_a, done_a});
    end
    checks++;
    if (fb_a.raddr !== 5'd0) begin
      failures++;
      $display("[TB] FAIL reset_raddr_a: got=%0d required=0", fb_a.raddr);
    end
    checks++;
    if ({sclk_b, sdata_b, lat_b, busy_b, done_b, fb_b.raddr} !== 10'b0) begin
      failures++;
      $display("[TB] FAIL reset_outputs_b: got=%b required=0", {sclk_b, sdata_b, lat_b, busy_b, done_b, fb_b.raddr});
    end
    start_a = 1'b1;
    repeat (2) tick();
    start_a = 1'b0;
    rst_a = 1'b0; rst_b = 1'b0;
    tick();
    checks++;
    if (busy_a !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_priority: busy=%b required=0", busy_a);
    end
  endtask

  task automatic test_single_word();
    logic [11:0] first_word = '0;
    int lat0, d0;
    for (int w = 0; w < 32; w++) mem_a[w] = '0;
    mem_a[0] = 12'h7FF;
    time_a = '0;
    build_exp_a(1);
    bits_a.delete();
    lat0 = lat_pulses_a; d0 = done_count_a;
    pulse_start_a();
    wait_done_a("single_word", d0 + 1);
    for (int i = 0; i < 12 && i < bits_a.size(); i++) first_word = {first_word[10:0], bits_a[i]};
    checks++;
    if (bits_a.size() != 384) begin
      failures++;
      $display("[TB] FAIL single_rise_count: got=%0d required=384", bits_a.size());
    end
    checks++;
    if (first_word !== 12'h7FF) begin
      failures++;
      $display("[TB] FAIL single_first_word: got=%h required=7ff", first_word);
    end
    checks++;
    if (stream_mismatch_a() != 0) begin
      failures++;
      $display("[TB] FAIL single_stream: mismatching bits=%0d required=0", stream_mismatch_a());
    end
    checks++;
    if (lat_pulses_a - lat0 != 1 || lat_width_a != 2) begin
      failures++;
      $display("[TB] FAIL single_latch: pulses=%0d width=%0d required 1 and 2", lat_pulses_a - lat0, lat_width_a);
    end
    checks++;
    if (done_idx_a - lat_fall_idx_a != 0) begin
      failures++;
      $display("[TB] FAIL single_done_gap: got=%0d required=0", done_idx_a - lat_fall_idx_a);
    end
    tick();
    checks++;
    if (busy_a !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_idle_after: busy=%b required=0", busy_a);
    end
  endtask

  task automatic test_random_frames();
    int d0;
    for (int f = 0; f < 3; f++) begin
      for (int w = 0; w < 32; w++) mem_a[w] = 12'($urandom);
      time_a = 10'($urandom_range(0, 4));
      build_exp_a(1);
      bits_a.delete();
      d0 = done_count_a;
      pulse_start_a();
      wait_done_a("random_frame", d0 + 1);
      checks++;
      if (stream_mismatch_a() != 0) begin
        failures++;
        $display("[TB] FAIL random_stream[%0d]: mismatching bits=%0d required=0", f, stream_mismatch_a());
      end
      checks++;
      if (lat_width_a != 2 || done_idx_a - lat_fall_idx_a != 2 * int'(time_a)) begin
        failures++;
        $display("[TB] FAIL random_timing[%0d]: lat width=%0d hold=%0d required 2 and %0d",
                 f, lat_width_a, done_idx_a - lat_fall_idx_a, 2 * int'(time_a));
      end
    end
  endtask

  task automatic test_hold_time();
    int lat0, d0, n, busy_low;
    for (int w = 0; w < 32; w++) mem_a[w] = 12'($urandom);
    time_a = 10'd3;
    build_exp_a(1);
    bits_a.delete();
    lat0 = lat_pulses_a; d0 = done_count_a;
    pulse_start_a();
    n = 0;
    while (lat_pulses_a == lat0 && n < 2000) begin tick(); n++; end
    checks++;
    if (lat_pulses_a == lat0) begin
      failures++;
      $display("[TB] FAIL hold_latch_timeout: latch pulses=%0d required=%0d", lat_pulses_a, lat0 + 1);
    end
    n = 0; busy_low = 0;
    while (done_a !== 1'b1 && n < 20) begin
      if (busy_a !== 1'b1) busy_low++;
      tick();
      n++;
    end
    checks++;
    if (n != 2 * 3) begin
      failures++;
      $display("[TB] FAIL hold_done_delay: got=%0d cycles required=6", n);
    end
    checks++;
    if (busy_low != 0 || busy_a !== 1'b0) begin
      failures++;
      $display("[TB] FAIL hold_busy: low samples=%0d busy at done=%b required 0 and 0", busy_low, busy_a);
    end
    checks++;
    if (stream_mismatch_a() != 0 || done_count_a != d0 + 1) begin
      failures++;
      $display("[TB] FAIL hold_stream: mismatching bits=%0d dones=%0d required 0 and %0d",
               stream_mismatch_a(), done_count_a - d0, 1);
    end
  endtask

  task automatic test_clkdiv2_pattern();
    int n = 0, bad = 0, idx;
    logic [11:0] word;
    for (int w = 0; w < 32; w++) mem_b[w] = 12'(w);
    time_b = '0;
    bits_b.delete();
    last_rise_b = -1;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    while (done_count_b < 1 && n < 4000) begin tick(); n++; end
    checks++;
    if (done_count_b < 1) begin
      failures++;
      $display("[TB] FAIL clkdiv2_timeout: done pulses=%0d required=1", done_count_b);
    end
    for (int w = 0; w < 32; w++) begin
      word = '0;
      for (int b = 0; b < 12; b++) begin
        idx = 12 * w + b;
        word = {word[10:0], (idx < bits_b.size()) ? bits_b[idx] : 1'b0};
      end
      if (word !== 12'(w)) bad++;
    end
    checks++;
    if (bits_b.size() != 384 || bad != 0) begin
      failures++;
      $display("[TB] FAIL clkdiv2_words: bits=%0d bad words=%0d required 384 and 0", bits_b.size(), bad);
    end
    checks++;
    if (period_viol_b != 0) begin
      failures++;
      $display("[TB] FAIL clkdiv2_period: violations=%0d required=0", period_viol_b);
    end
  endtask

  task automatic test_reset_midframe();
    int n = 0, d0;
    for (int w = 0; w < 32; w++) mem_a[w] = 12'($urandom);
    time_a = 10'd1;
    bits_a.delete();
    pulse_start_a();
    while (bits_a.size() < 68 && n < 1000) begin tick(); n++; end
    checks++;
    if (bits_a.size() != 68 || fb_a.raddr !== 5'd6) begin
      failures++;
      $display("[TB] FAIL midframe_position: bits=%0d raddr=%0d required 68 and 6", bits_a.size(), fb_a.raddr);
    end
    rst_a = 1'b1;
    tick();
    checks++;
    if ({sclk_a, sdata_a, lat_a, busy_a, done_a, fb_a.raddr} !== 10'b0) begin
      failures++;
      $display("[TB] FAIL midframe_reset: got=%b required=0", {sclk_a, sdata_a, lat_a, busy_a, done_a, fb_a.raddr});
    end
    rst_a = 1'b0;
    tick();
    for (int w = 0; w < 32; w++) mem_a[w] = 12'($urandom);
    build_exp_a(1);
    bits_a.delete();
    d0 = done_count_a;
    pulse_start_a();
    checks++;
    if (busy_a !== 1'b1 || fb_a.raddr !== 5'd0) begin
      failures++;
      $display("[TB] FAIL restart_fetch: busy=%b raddr=%0d required 1 and 0", busy_a, fb_a.raddr);
    end
    wait_done_a("restart", d0 + 1);
    checks++;
    if (stream_mismatch_a() != 0) begin
      failures++;
      $display("[TB] FAIL restart_stream: mismatching bits=%0d required=0", stream_mismatch_a());
    end
  endtask

  task automatic test_back_to_back();
    int d0;
    for (int w = 0; w < 32; w++) mem_a[w] = 12'($urandom);
    time_a = 10'($urandom_range(0, 2));
    build_exp_a(2);
    bits_a.delete();
    d0 = done_count_a;
    start_a = 1'b1;
    wait_done_a("b2b_first", d0 + 1);
    tick();
    checks++;
    if (busy_a !== 1'b1 || fb_a.raddr !== 5'd0) begin
      failures++;
      $display("[TB] FAIL b2b_refetch: busy=%b raddr=%0d required 1 and 0", busy_a, fb_a.raddr);
    end
    for (int i = 0; i < 150; i++) begin
      start_a = 1'($urandom);
      tick();
    end
    start_a = 1'b0;
    wait_done_a("b2b_second", d0 + 2);
    repeat (10) tick();
    checks++;
    if (done_count_a != d0 + 2 || busy_a !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_frames: dones=%0d busy=%b required 2 and 0", done_count_a - d0, busy_a);
    end
    checks++;
    if (stream_mismatch_a() != 0) begin
      failures++;
      $display("[TB] FAIL b2b_stream: mismatching bits=%0d required=0", stream_mismatch_a());
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (sdata_viol_a != 0 || sdata_viol_b != 0) begin
      failures++;
      $display("[TB] FAIL sdata_stable: changes while sclk high a=%0d b=%0d required 0", sdata_viol_a, sdata_viol_b);
    end
    checks++;
    if (raddr_viol_a != 0 || raddr_viol_b != 0) begin
      failures++;
      $display("[TB] FAIL raddr_no_wrap: backward steps a=%0d b=%0d required 0", raddr_viol_a, raddr_viol_b);
    end
  endtask

  initial begin
    for (int w = 0; w < 32; w++) begin
      mem_a[w] = '0;
      mem_b[w] = '0;
    end
    test_reset();
    test_single_word();
    test_random_frames();
    test_hold_time();
    test_clkdiv2_pattern();
    test_reset_midframe();
    test_back_to_back();
    test_invariants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
